// File: rtl/gptp_rx_pkg.sv
// Shared constants, types and helpers for the gPTP receive parser.
package gptp_rx_pkg;

  localparam int unsigned TS_W      = 32'd80;
  localparam int unsigned CNT_W     = 32'd11;
  localparam logic [15:0] PTP_ETYPE = 16'h88F7;

  localparam logic [10:0] MIN_LEN     = 11'd58;
  localparam logic [10:0] ETH_HDR_LEN = 11'd14;
  localparam logic [10:0] CNT_MAX     = 11'h7FF;

  // Field offsets within the PTP message (PTP byte k is frame byte 14+k)
  localparam logic [10:0] OFF_CORR = 11'd8;
  localparam logic [10:0] OFF_SPID = 11'd20;
  localparam logic [10:0] OFF_SEQ  = 11'd30;
  localparam logic [10:0] OFF_TS   = 11'd34;

  // Supported messageType codes
  localparam logic [3:0] MT_SYNC          = 4'h0;
  localparam logic [3:0] MT_PDLY_REQ      = 4'h2;
  localparam logic [3:0] MT_PDLY_RESP     = 4'h3;
  localparam logic [3:0] MT_FOLLOW_UP     = 4'h8;
  localparam logic [3:0] MT_PDLY_RESP_FUP = 4'hA;
  localparam logic [3:0] MT_ANNOUNCE      = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ETH  = 2'd1,
    PTP  = 2'd2,
    SKIP = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [3:0]      msg_type;
    logic [15:0]     seq_id;
    logic [63:0]     correction;
    logic [79:0]     src_port_id;
    logic [TS_W-1:0] origin_ts;
    logic [TS_W-1:0] ingress_ts;
  } gptp_msg_t;

  // True when the messageType is one the protocol machines handle
  function automatic logic type_supported(input logic [3:0] mt);
    logic ok;
    case (mt)
      MT_SYNC, MT_PDLY_REQ, MT_PDLY_RESP,
      MT_FOLLOW_UP, MT_PDLY_RESP_FUP, MT_ANNOUNCE: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when PTP byte k lies inside the field [off, off+len)
  function automatic logic in_field(input logic [10:0] k,
                                    input logic [10:0] off,
                                    input logic [10:0] len);
    return (k >= off) && (k < (off + len));
  endfunction

endpackage

// File: rtl/gptp_rx_msg_buf.sv
// Single-entry valid/ready holding register for parsed gPTP messages.
// A load is taken when the entry is empty or being popped the same cycle;
// otherwise the held message is kept and full_drop flags the lost frame.
module gptp_rx_msg_buf
  import gptp_rx_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  gptp_msg_t load_msg,
  input  logic      msg_ready,
  output logic      msg_valid,
  output gptp_msg_t msg,
  output logic      full_drop
);

  logic      valid_r;
  gptp_msg_t msg_r;
  logic      pop_s;
  logic      load_ok_s;

  // Load/pop arbitration: a pop in the same cycle frees the entry for a new load
  always_comb begin
    pop_s     = valid_r & msg_ready;
    load_ok_s = load & (~valid_r | pop_s);
    full_drop = load & ~load_ok_s;
  end

  // Holding register; fields are only written by an accepted load
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      msg_r   <= '0;
    end else if (load_ok_s) begin
      valid_r <= 1'b1;
      msg_r   <= load_msg;
    end else if (pop_s) begin
      valid_r <= 1'b0;
      msg_r   <= msg_r;
    end else begin
      valid_r <= valid_r;
      msg_r   <= msg_r;
    end
  end

  assign msg_valid = valid_r;
  assign msg       = msg_r;

endmodule

// File: rtl/gptp_rx_parser.sv
// Receive-side gPTP frame parser: checks EtherType and PTP header, captures
// the common header fields and timestamp body, and hands one message per
// accepted frame to a single-entry output buffer. Dropped frames are counted.
module gptp_rx_parser
  import gptp_rx_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  input  logic            rx_sof,
  input  logic            rx_eof,
  input  logic            rx_err,
  input  logic [TS_W-1:0] rx_ts,
  output logic            msg_valid,
  input  logic            msg_ready,
  output logic [3:0]      msg_type,
  output logic [15:0]     msg_seq_id,
  output logic [63:0]     msg_correction,
  output logic [79:0]     msg_src_port_id,
  output logic [TS_W-1:0] msg_origin_ts,
  output logic [TS_W-1:0] msg_ingress_ts,
  output logic [15:0]     drop_cnt
);

  rx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       etype_hi_r;
  logic [TS_W-1:0]  ingress_r;
  logic [3:0]       wk_type_r;
  logic [15:0]      wk_seq_r;
  logic [63:0]      wk_corr_r;
  logic [79:0]      wk_spid_r;
  logic [TS_W-1:0]  wk_ts_r;
  logic [15:0]      drop_cnt_r;

  logic             sof_s;
  logic             eof_s;
  logic             abort_s;
  rx_state_t        cur_state_s;
  logic [CNT_W-1:0] idx_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] k_s;
  logic             etype_ok_s;
  logic             ptp_bad_s;
  logic             accept_s;
  logic             frame_drop_s;
  logic             full_drop_s;

  logic [3:0]       wk_type_nxt_s;
  logic [15:0]      wk_seq_nxt_s;
  logic [63:0]      wk_corr_nxt_s;
  logic [79:0]      wk_spid_nxt_s;
  logic [TS_W-1:0]  wk_ts_nxt_s;
  logic [TS_W-1:0]  ingress_nxt_s;

  logic [1:0]       drop_inc_s;
  logic [16:0]      drop_sum_s;
  logic [15:0]      drop_cnt_nxt_s;

  gptp_msg_t        load_msg_s;
  gptp_msg_t        buf_msg_s;
  logic             buf_valid_s;

  // Per-beat decode: byte index, state seen by this beat, header checks and frame verdict
  always_comb begin
    sof_s   = rx_valid & rx_sof;
    eof_s   = rx_valid & rx_eof;
    abort_s = sof_s & (state_r != IDLE);
    if (sof_s) begin
      idx_s       = '0;
      cur_state_s = ETH;
    end else begin
      idx_s       = cnt_r;
      cur_state_s = state_r;
    end
    if (idx_s == CNT_MAX) begin
      cnt_nxt_s = idx_s;
    end else begin
      cnt_nxt_s = idx_s + 11'd1;
    end
    k_s        = idx_s - ETH_HDR_LEN;
    etype_ok_s = ({etype_hi_r, rx_data} == PTP_ETYPE);
    if (k_s == 11'd0) begin
      ptp_bad_s = (rx_data[7:4] != 4'h1) || !type_supported(rx_data[3:0]);
    end else if (k_s == 11'd1) begin
      ptp_bad_s = (rx_data[3:0] != 4'h2);
    end else begin
      ptp_bad_s = 1'b0;
    end
    // cnt_nxt_s is the frame length when this beat is the last one
    accept_s     = eof_s && (cur_state_s == PTP) && !ptp_bad_s &&
                   (cnt_nxt_s >= MIN_LEN) && !rx_err;
    frame_drop_s = eof_s && (cur_state_s != IDLE) && !accept_s;
  end

  // Working-register capture: field bytes shift in MSB-first at their PTP offsets
  always_comb begin
    wk_type_nxt_s = wk_type_r;
    wk_seq_nxt_s  = wk_seq_r;
    wk_corr_nxt_s = wk_corr_r;
    wk_spid_nxt_s = wk_spid_r;
    wk_ts_nxt_s   = wk_ts_r;
    if (cur_state_s == PTP) begin
      if (k_s == 11'd0) begin
        wk_type_nxt_s = rx_data[3:0];
      end else begin
        wk_type_nxt_s = wk_type_r;
      end
      if (in_field(k_s, OFF_CORR, 11'd8)) begin
        wk_corr_nxt_s = {wk_corr_r[55:0], rx_data};
      end else begin
        wk_corr_nxt_s = wk_corr_r;
      end
      if (in_field(k_s, OFF_SPID, 11'd10)) begin
        wk_spid_nxt_s = {wk_spid_r[71:0], rx_data};
      end else begin
        wk_spid_nxt_s = wk_spid_r;
      end
      if (in_field(k_s, OFF_SEQ, 11'd2)) begin
        wk_seq_nxt_s = {wk_seq_r[7:0], rx_data};
      end else begin
        wk_seq_nxt_s = wk_seq_r;
      end
      if (in_field(k_s, OFF_TS, 11'd10)) begin
        wk_ts_nxt_s = {wk_ts_r[TS_W-9:0], rx_data};
      end else begin
        wk_ts_nxt_s = wk_ts_r;
      end
    end else begin
      wk_type_nxt_s = wk_type_r;
    end
    if (sof_s) begin
      ingress_nxt_s = rx_ts;
    end else begin
      ingress_nxt_s = ingress_r;
    end
  end

  // Message presented to the output buffer, including the byte arriving on the eof beat
  always_comb begin
    load_msg_s.msg_type    = wk_type_nxt_s;
    load_msg_s.seq_id      = wk_seq_nxt_s;
    load_msg_s.correction  = wk_corr_nxt_s;
    load_msg_s.src_port_id = wk_spid_nxt_s;
    load_msg_s.origin_ts   = wk_ts_nxt_s;
    load_msg_s.ingress_ts  = ingress_nxt_s;
  end

  // Saturating drop counter; an abort and a one-beat frame can land on the same beat
  always_comb begin
    drop_inc_s = {1'b0, abort_s} + {1'b0, frame_drop_s} + {1'b0, full_drop_s};
    drop_sum_s = {1'b0, drop_cnt_r} + {15'd0, drop_inc_s};
    if (drop_sum_s[16]) begin
      drop_cnt_nxt_s = 16'hFFFF;
    end else begin
      drop_cnt_nxt_s = drop_sum_s[15:0];
    end
  end

  // Frame FSM, byte counter and working registers; nothing moves without a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      etype_hi_r <= 8'h00;
      ingress_r  <= '0;
      wk_type_r  <= 4'h0;
      wk_seq_r   <= 16'h0000;
      wk_corr_r  <= 64'h0;
      wk_spid_r  <= 80'h0;
      wk_ts_r    <= '0;
      drop_cnt_r <= 16'h0000;
    end else if (rx_valid) begin
      cnt_r      <= cnt_nxt_s;
      ingress_r  <= ingress_nxt_s;
      wk_type_r  <= wk_type_nxt_s;
      wk_seq_r   <= wk_seq_nxt_s;
      wk_corr_r  <= wk_corr_nxt_s;
      wk_spid_r  <= wk_spid_nxt_s;
      wk_ts_r    <= wk_ts_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
      if (idx_s == 11'd12) begin
        etype_hi_r <= rx_data;
      end else begin
        etype_hi_r <= etype_hi_r;
      end
      case (cur_state_s)
        IDLE: state_r <= IDLE;
        ETH: begin
          if (eof_s) begin
            state_r <= IDLE;
          end else if (idx_s == 11'd13) begin
            state_r <= etype_ok_s ? PTP : SKIP;
          end else begin
            state_r <= ETH;
          end
        end
        PTP: begin
          if (eof_s) begin
            state_r <= IDLE;
          end else if (ptp_bad_s) begin
            state_r <= SKIP;
          end else begin
            state_r <= PTP;
          end
        end
        SKIP:    state_r <= eof_s ? IDLE : SKIP;
        default: state_r <= IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  gptp_rx_msg_buf u_msg_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_s),
    .load_msg  (load_msg_s),
    .msg_ready (msg_ready),
    .msg_valid (buf_valid_s),
    .msg       (buf_msg_s),
    .full_drop (full_drop_s)
  );

  assign msg_valid       = buf_valid_s;
  assign msg_type        = buf_msg_s.msg_type;
  assign msg_seq_id      = buf_msg_s.seq_id;
  assign msg_correction  = buf_msg_s.correction;
  assign msg_src_port_id = buf_msg_s.src_port_id;
  assign msg_origin_ts   = buf_msg_s.origin_ts;
  assign msg_ingress_ts  = buf_msg_s.ingress_ts;
  assign drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_gptp_rx_parser.sv
// Self-checking bench for gptp_rx_parser: directed scenarios plus randomized
// frames compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_gptp_rx_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_sof, rx_eof, rx_err;
  logic [7:0]  rx_data;
  logic [79:0] rx_ts;
  logic        msg_valid, msg_ready;
  logic [3:0]  msg_type;
  logic [15:0] msg_seq_id;
  logic [63:0] msg_correction;
  logic [79:0] msg_src_port_id, msg_origin_ts, msg_ingress_ts;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  gptp_rx_parser dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err), .rx_ts(rx_ts),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type),
    .msg_seq_id(msg_seq_id), .msg_correction(msg_correction),
    .msg_src_port_id(msg_src_port_id), .msg_origin_ts(msg_origin_ts),
    .msg_ingress_ts(msg_ingress_ts), .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  t;
    logic [15:0] seq;
    logic [63:0] corr;
    logic [79:0] spid;
    logic [79:0] ts;
    logic [79:0] ing;
  } exp_msg_t;

  exp_msg_t   exp_q[$];
  exp_msg_t   mon_m;
  logic [7:0] fq[$];
  int         mdl_drops = 0;
  bit         mdl_held = 0;
  bit         mdl_in_frame = 0;

  function automatic void mdl_drop();
    if (mdl_drops < 65535) mdl_drops++;
  endfunction

  function automatic logic [127:0] field_be(input int first, input int n);
    logic [127:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 128'(fq[first + i]);
    return v;
  endfunction

  // Reference: frame-level accept rule and field extraction from the byte list
  function automatic bit mdl_parse(input bit err, output exp_msg_t m);
    logic [7:0] b0, b1;
    m = '{default: '0};
    if (fq.size() < 58 || err) return 1'b0;
    if (field_be(12, 2) != 128'h88F7) return 1'b0;
    b0 = fq[14];
    b1 = fq[15];
    if (b0[7:4] != 4'h1 || b1[3:0] != 4'h2) return 1'b0;
    if (!(b0[3:0] inside {4'h0, 4'h2, 4'h3, 4'h8, 4'hA, 4'hB})) return 1'b0;
    m.t    = b0[3:0];
    m.corr = 64'(field_be(14 + 8, 8));
    m.spid = 80'(field_be(14 + 20, 10));
    m.seq  = 16'(field_be(14 + 30, 2));
    m.ts   = 80'(field_be(14 + 34, 10));
    return 1'b1;
  endfunction

  task automatic put_be(input int first, input int n, input logic [127:0] v);
    for (int i = 0; i < n; i++)
      if (first + i < fq.size()) fq[first + i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic build(input int len, input logic [15:0] etype, input logic [3:0] sdo,
                       input logic [3:0] ver, input logic [3:0] mt, input logic [15:0] seq,
                       input logic [63:0] corr, input logic [79:0] spid, input logic [79:0] ts);
    fq.delete();
    for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
    put_be(12, 2, 128'(etype));
    put_be(14, 1, 128'({sdo, mt}));
    put_be(15, 1, 128'({4'($urandom), ver}));
    put_be(22, 8, 128'(corr));
    put_be(34, 10, 128'(spid));
    put_be(44, 2, 128'(seq));
    put_be(48, 10, 128'(ts));
  endtask

  // gap: 0 none, 1 idle before every beat, 2 random 0..2 idles
  task automatic drive(input int n, input bit with_eof, input bit err, input int gap,
                       input logic [79:0] sof_ts);
    for (int i = 0; i < n; i++) begin
      int idles;
      idles = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
      repeat (idles) begin
        rx_valid = 1'b0; rx_sof = 1'($urandom); rx_eof = 1'($urandom);
        rx_err = 1'($urandom); rx_data = 8'($urandom);
        rx_ts = 80'({$urandom, $urandom, $urandom});
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = fq[i];
      rx_sof   = (i == 0);
      rx_eof   = with_eof && (i == n - 1);
      rx_err   = (with_eof && (i == n - 1)) ? err : 1'($urandom);
      rx_ts    = (i == 0) ? sof_ts : 80'({$urandom, $urandom, $urandom});
      @(posedge clk); #1;
    end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
  endtask

  task automatic send_frame(input bit err, input int gap, input logic [79:0] sof_ts);
    exp_msg_t m;
    bit acc;
    if (mdl_in_frame) mdl_drop();
    mdl_in_frame = 1'b0;
    acc = mdl_parse(err, m);
    m.ing = sof_ts;
    drive(fq.size(), 1'b1, err, gap, sof_ts);
    if (!acc || mdl_held) begin
      mdl_drop();
    end else begin
      exp_q.push_back(m);
      if (!msg_ready) mdl_held = 1'b1;
    end
    chk("valid_after_eof", 96'(msg_valid), 96'(acc | mdl_held));
    chk("drop_cnt", 96'(drop_cnt), 96'(mdl_drops));
  endtask

  task automatic send_partial(input int n, input logic [79:0] sof_ts);
    if (mdl_in_frame) mdl_drop();
    drive(n, 1'b0, 1'b0, 0, sof_ts);
    mdl_in_frame = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_drops = 0; mdl_held = 1'b0; mdl_in_frame = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every handshake must deliver the oldest expected message
  always @(negedge clk) begin
    if (!rst && msg_valid && msg_ready) begin
      if (exp_q.size() == 0) begin
        chk("msg_expected", 96'(exp_q.size() != 0), 96'd1);
      end else begin
        mon_m = exp_q.pop_front();
        chk("msg_type", 96'(msg_type), 96'(mon_m.t));
        chk("msg_seq_id", 96'(msg_seq_id), 96'(mon_m.seq));
        chk("msg_correction", 96'(msg_correction), 96'(mon_m.corr));
        chk("msg_src_port_id", 96'(msg_src_port_id), 96'(mon_m.spid));
        chk("msg_origin_ts", 96'(msg_origin_ts), 96'(mon_m.ts));
        chk("msg_ingress_ts", 96'(msg_ingress_ts), 96'(mon_m.ing));
      end
    end
  end

  logic [63:0] s_corr;
  logic [79:0] s_spid;
  logic [3:0]  good_t[6] = '{4'h0, 4'h2, 4'h3, 4'h8, 4'hA, 4'hB};

  initial begin
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
    rx_data = 8'h00; rx_ts = '0; msg_ready = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_valid", 96'(msg_valid), 96'd0);
    chk("reset_drop", 96'(drop_cnt), 96'd0);
    chk("reset_seq", 96'(msg_seq_id), 96'd0);
    chk("reset_origin", 96'(msg_origin_ts), 96'd0);

    // Sync, 58 bytes, gap-free
    s_corr = {$urandom, $urandom};
    s_spid = 80'({$urandom, $urandom, $urandom});
    build(58, 16'h88F7, 4'h1, 4'h2, 4'h0, 16'h1234, s_corr, s_spid, 80'h000000000005_3B9AC9FF);
    send_frame(1'b0, 0, 80'h64);

    // Foreign EtherType, rx_err, 57-byte frame
    build(60, 16'h0800, 4'h1, 4'h2, 4'h0, 16'h1, s_corr, s_spid, 80'h1);
    send_frame(1'b0, 0, 80'h1);
    build(60, 16'h88F7, 4'h1, 4'h2, 4'h0, 16'h2, s_corr, s_spid, 80'h2);
    send_frame(1'b1, 0, 80'h2);
    build(57, 16'h88F7, 4'h1, 4'h2, 4'h0, 16'h3, s_corr, s_spid, 80'h3);
    send_frame(1'b0, 0, 80'h3);
    chk("three_drops", 96'(drop_cnt), 96'd3);

    // Output full: second Follow_Up dropped, first held
    do_reset();
    msg_ready = 1'b0;
    build(62, 16'h88F7, 4'h1, 4'h2, 4'h8, 16'h0001, s_corr, s_spid, 80'h10);
    send_frame(1'b0, 0, 80'h10);
    build(62, 16'h88F7, 4'h1, 4'h2, 4'h8, 16'h0002, s_corr, s_spid, 80'h20);
    send_frame(1'b0, 0, 80'h20);
    chk("held_seq", 96'(msg_seq_id), 96'd1);
    chk("full_drop", 96'(drop_cnt), 96'd1);
    msg_ready = 1'b1;
    @(posedge clk); #1;
    mdl_held = 1'b0;
    chk("valid_after_pop", 96'(msg_valid), 96'd0);

    // Abort at byte 30, then Pdelay_Resp seq 7
    do_reset();
    build(70, 16'h88F7, 4'h1, 4'h2, 4'h0, 16'h0099, s_corr, s_spid, 80'h55);
    send_partial(30, 80'h55);
    build(58, 16'h88F7, 4'h1, 4'h2, 4'h3, 16'h0007, s_corr, s_spid, 80'hABC);
    send_frame(1'b0, 0, 80'h777);
    chk("abort_drop", 96'(drop_cnt), 96'd1);

    // Reset mid-frame, then Announce
    build(70, 16'h88F7, 4'h1, 4'h2, 4'h0, 16'h0042, s_corr, s_spid, 80'h9);
    send_partial(20, 80'h9);
    do_reset();
    build(64, 16'h88F7, 4'h1, 4'h2, 4'hB, 16'h0100, s_corr, s_spid, 80'hDEAD);
    send_frame(1'b0, 0, 80'h321);
    chk("reset_no_drop", 96'(drop_cnt), 96'd0);

    // Sync with rx_valid toggling; then unsupported type 0x9
    build(58, 16'h88F7, 4'h1, 4'h2, 4'h0, 16'h1234, s_corr, s_spid, 80'h000000000005_3B9AC9FF);
    send_frame(1'b0, 1, 80'h64);
    build(58, 16'h88F7, 4'h1, 4'h2, 4'h9, 16'h1235, s_corr, s_spid, 80'h5);
    send_frame(1'b0, 0, 80'h65);

    // Randomized frames
    for (int f = 0; f < 80; f++) begin
      int cat, len;
      logic [15:0] et;
      logic [3:0] sdo, ver, mt;
      cat = int'($urandom_range(0, 7));
      len = (cat == 7) ? int'($urandom_range(1, 57)) : int'($urandom_range(58, 90));
      et  = (cat == 3) ? (($urandom_range(0, 1) == 0) ? 16'h8100 : 16'($urandom)) : 16'h88F7;
      sdo = 4'h1; ver = 4'h2;
      mt  = good_t[$urandom_range(0, 5)];
      if (cat == 4) begin sdo = 4'($urandom); if (sdo == 4'h1) sdo = 4'h0; end
      if (cat == 5) begin ver = 4'($urandom); if (ver == 4'h2) ver = 4'h1; end
      if (cat == 6) begin
        mt = 4'($urandom);
        while (mt inside {4'h0, 4'h2, 4'h3, 4'h8, 4'hA, 4'hB}) mt = 4'($urandom);
      end
      build(len, et, sdo, ver, mt, 16'($urandom), {$urandom, $urandom},
            80'({$urandom, $urandom, $urandom}), 80'({$urandom, $urandom, $urandom}));
      send_frame($urandom_range(0, 7) == 0, int'($urandom_range(0, 2)),
                 80'({$urandom, $urandom, $urandom}));
    end

    // Drop counter saturation with one-beat frames
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      rx_valid = 1'b1; rx_sof = 1'b1; rx_eof = 1'b1; rx_err = 1'b0;
      rx_data = 8'($urandom);
      @(posedge clk); #1;
      mdl_drop();
      if (i == 65533) chk("drop_cnt_fffe", 96'(drop_cnt), 96'(mdl_drops));
    end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    chk("drop_cnt_sat", 96'(drop_cnt), 96'hFFFF);
    chk("sat_valid", 96'(msg_valid), 96'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 96'(exp_q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gptp_rx_parser.md
Name: gptp_rx_parser

Overview:
- Receive-side gPTP frame parser. Sits between the MAC receive byte stream and the gPTP protocol state machines, mirroring the transmit path.
- Recognises untagged 802.1AS frames (EtherType 0x88F7), extracts the common PTP header fields and the 10-byte timestamp body, and captures the local ingress timestamp at start of frame.
- Presents one parsed message per frame on a valid/ready output. Bad, short, foreign or overflowing frames are dropped and counted.

Parameters:
- TS_W, 80, timestamp width: 48-bit seconds, then 32-bit nanoseconds, big-endian as on the wire.
- PTP_ETYPE, 16'h88F7, accepted EtherType.
- MIN_LEN, 58, minimum frame bytes: 14 Ethernet + 44 PTP header/body.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rx_valid  in  1  byte beat valid; gaps allowed between beats
- rx_data  in  8  frame byte, destination MAC first, FCS already stripped
- rx_sof  in  1  first byte of frame; qualified by rx_valid
- rx_eof  in  1  last byte of frame; qualified by rx_valid
- rx_err  in  1  frame error (e.g. CRC); sampled on the eof beat only
- rx_ts  in  TS_W  free-running local time
- msg_valid  out  1  parsed message available
- msg_ready  in  1  consumer accepts message
- msg_type  out  4  messageType
- msg_seq_id  out  16  sequenceId
- msg_correction  out  64  correctionField
- msg_src_port_id  out  80  sourcePortIdentity
- msg_origin_ts  out  TS_W  timestamp body
- msg_ingress_ts  out  TS_W  rx_ts latched on the sof beat
- drop_cnt  out  16  saturating count of dropped frames

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): FSM goes to IDLE. msg_valid=0, all msg_* fields=0, drop_cnt=0, byte counter=0. A reset mid-frame discards that frame and does not count it.
- Byte counter: 11 bits, cleared on sof, increments on each valid beat, saturates at 2047.
- PTP byte k is frame byte 14+k.
- FSM states:
  - IDLE: waits for rx_valid&rx_sof, latches rx_ts, goes to ETH.
  - ETH: frame bytes 12-13 must equal PTP_ETYPE, else SKIP.
  - PTP: captures fields; any failed check goes to SKIP.
  - SKIP: drains bytes until eof, then IDLE.
- Checks in PTP state:
  - PTP byte 0 high nibble (majorSdoId) must be 1.
  - PTP byte 1 low nibble (versionPTP) must be 2.
  - messageType must be in {0x0,0x2,0x3,0x8,0xA,0xB}.
- Field capture offsets (PTP bytes):
  - msg_type: byte 0[3:0]
  - msg_correction: bytes 8-15
  - msg_src_port_id: bytes 20-29
  - msg_seq_id: bytes 30-31
  - msg_origin_ts: bytes 34-43
  - Capture goes into working registers, shifted MSB-first.
- Frame acceptance on the eof beat requires all of: state PTP, byte count ≥ MIN_LEN, rx_err=0. Anything else is a drop.
- Output register is a single entry, separate from the working registers. An accepted frame loads it when it is empty or being popped that cycle (msg_valid&msg_ready). Otherwise the new frame is dropped; the held message is never overwritten.
- Latency: msg_valid rises the cycle after the eof beat. All msg_* fields stay stable while msg_valid=1 and msg_ready=0. msg_valid drops the cycle after the handshake unless reloaded in the same cycle.
- Drops: each drop increments drop_cnt by 1, saturating at 0xFFFF. Drop causes:
  - foreign EtherType
  - bad SDO or version
  - unsupported type
  - short frame
  - rx_err
  - output full
  - aborted frame
- Aborted frame: rx_sof arriving while not IDLE counts one drop, restarts at ETH and latches a new ingress timestamp.
- Other boundary cases:
  - sof and eof on the same beat: drop.
  - eof in ETH state: drop.
  - rx_valid=0: no state change.
  - rx_sof/rx_eof/rx_err are ignored when rx_valid=0.
- Frames tagged 0x8100 are foreign (untagged only).

Decomposition:
- Package gptp_rx_pkg holds:
  - PTP_ETYPE
  - MIN_LEN
  - ETH_HDR_LEN=14
  - field offset constants (OFF_CORR=8, OFF_SPID=20, OFF_SEQ=30, OFF_TS=34)
  - message type codes (SYNC, PDLY_REQ, PDLY_RESP, FOLLOW_UP, PDLY_RESP_FUP, ANNOUNCE)
  - FSM state enum {IDLE, ETH, PTP, SKIP}
  - TS_W
- One sub-module: gptp_rx_msg_buf, the single-entry valid/ready output holding register with load/pop arbitration and drop-on-full indication.

Test Plan:
- Sync frame, 58 bytes, seq 0x1234, ts body 0x000000000005_3B9AC9FF, rx_ts=80'h64 at sof, msg_ready=1 -> msg_valid one cycle after eof with:
  - msg_type=0
  - msg_seq_id=0x1234
  - msg_origin_ts as sent
  - msg_ingress_ts=80'h64
  - drop_cnt=0
- EtherType 0x0800 frame, then frame with rx_err=1 on eof, then 57-byte PTP frame -> no msg_valid, drop_cnt=3.
- msg_ready=0, two valid Follow_Up frames back-to-back (seq 1, 2) -> msg_seq_id stays 1, drop_cnt=1. Raise msg_ready -> single pop, msg_valid=0 next cycle.
- rx_sof at byte 30 of a frame, followed by a complete Pdelay_Resp (type 3, seq 7) -> drop_cnt=1, message seq 7 delivered with ingress ts taken at the second sof.
- Assert rst for one cycle mid-frame, then send a valid Announce -> drop_cnt stays 0, msg_type=0xB delivered. Also: 70000 dropped frames leave drop_cnt=0xFFFF.
- rx_valid toggling 1/0 every cycle during a valid Sync -> identical fields to the gap-free case. messageType 0x9 -> dropped.
